// File: rtl/conv_fprop1_mul_arb.sv
// conv_fprop1_mul_arb
//   Shares one ce-gated pipelined 32x32 signed multiplier among NUM_REQ
//   operand requesters. At most one request is granted per cycle. The
//   requester ID of each in-flight product travels through a shadow pipeline
//   that matches the multiplier depth. Products come back on one tagged
//   response port. Backpressure on that port freezes the multiplier and the
//   shadow pipeline together.
//
//   Build option: define CONV_FPROP1_MUL_ARB_PRIO_EN to select fixed priority
//   (lowest index wins). In that build ptr holds its reset value. By default
//   the arbiter is round-robin.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   req_valid / req_ready   per-requester handshake (grant is one-hot or zero)
//   req_a / req_b           packed operands, requester i at [32i+31:32i]
//   mul_din0/din1/ce/dout   multiplier interface
//   rsp_valid/ready/id/data tagged product response (data = mul_dout)
//   busy                    a product is in flight or on the response port
module conv_fprop1_mul_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3,
   parameter int MUL_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   output logic [31:0]            mul_din0,
   output logic [31:0]            mul_din1,
   output logic                   mul_ce,
   input  logic [31:0]            mul_dout,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_data,
   output logic                   busy
);

   logic [MUL_LAT-1:0] vld;
   logic [ID_W-1:0]    id [MUL_LAT];
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    pick;
   logic               found;
   logic               advance;
   logic               transfer;

   // Gating with reset_n keeps every grant and ce output quiet while the
   // block is held in reset, even when requesters are still asserting valid.
   assign advance  = reset_n && (!vld[MUL_LAT-1] || rsp_ready);
   assign transfer = advance && found;

`ifdef CONV_FPROP1_MUL_ARB_PRIO_EN
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_valid[j]) begin
            found = 1'b1;
            pick  = ID_W'(j);
         end
      end
   end
`else
   // The scan runs from the farthest slot to the nearest slot, so the last
   // hit is the nearest one after ptr. Offset k = NUM_REQ is ptr itself,
   // which therefore has the lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] && (((int'(ptr) + k) % NUM_REQ) == j)) begin
               found = 1'b1;
               pick  = ID_W'(j);
            end
         end
      end
   end
`endif

   always_comb begin
      req_ready = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (transfer && (pick == ID_W'(j))) begin
            req_ready[j] = 1'b1;
            mul_din0     = req_a[32*j +: 32];
            mul_din1     = req_b[32*j +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
         for (int k = 0; k < MUL_LAT; k++) id[k] <= '0;
         ptr <= ID_W'(NUM_REQ - 1);
      end else if (advance) begin
         vld[0] <= transfer;
         id[0]  <= transfer ? pick : '0;
         for (int k = 1; k < MUL_LAT; k++) begin
            vld[k] <= vld[k-1];
            id[k]  <= id[k-1];
         end
`ifndef CONV_FPROP1_MUL_ARB_PRIO_EN
         if (transfer) ptr <= pick;
`endif
      end
   end

   assign mul_ce    = advance;
   assign rsp_valid = vld[MUL_LAT-1];
   assign rsp_id    = id[MUL_LAT-1];
   assign rsp_data  = mul_dout;
   assign busy      = |vld;

endmodule

// File: tb/tb_conv_fprop1_mul_arb.sv
// Testbench for conv_fprop1_mul_arb (NUM_REQ=4, MUL_LAT=1). It includes a
// ce-gated behavioural model of the shared multiplier. A per-cycle table of
// hand-computed vectors checks round-robin order, overflow wrap and the stall
// sequence. Hand-written sequences check the reset state, a reset taken in
// the middle of operation, and fixed-priority mode when that build option is
// defined.
module tb_conv_fprop1_mul_arb;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 3;
   localparam int MUL_LAT = 1;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [31:0]           mul_din0;
   logic [31:0]           mul_din1;
   logic                  mul_ce;
   logic [31:0]           mul_dout;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_data;
   logic                  busy;

   int n_cmp = 0;
   int n_bad = 0;

   conv_fprop1_mul_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce), .mul_dout(mul_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural model of the shared multiplier: ce-gated, MUL_LAT stages.
   logic [31:0]        mstage [MUL_LAT];
   logic signed [63:0] prod;
   assign prod     = $signed(mul_din0) * $signed(mul_din1);
   assign mul_dout = mstage[MUL_LAT-1];
   always @(posedge clk) begin
      if (mul_ce) begin
         mstage[0] <= prod[31:0];
         for (int k = 1; k < MUL_LAT; k++) mstage[k] <= mstage[k-1];
      end
   end

   typedef struct packed {
      logic [3:0]  vin;
      logic [31:0] abase;
      logic [31:0] b;
      logic        rr;
      logic [3:0]  exp_ready;
      logic        exp_ce;
      logic        exp_rv;
      logic [2:0]  exp_id;
      logic [31:0] exp_data;
      logic        exp_busy;
   } vec_t;

   vec_t tv [20];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
      end
   endtask

   // Requester i is given operand A = abase + i and operand B = b, so the
   // product identifies which requester the mux selected.
   task automatic drive(input logic [3:0] vin, input logic [31:0] abase,
                        input logic [31:0] b, input logic rr);
      req_valid = vin;
      rsp_ready = rr;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[32*i +: 32] = abase + 32'(i);
         req_b[32*i +: 32] = b;
      end
   endtask

   task automatic chk_reset_outputs(input int idx);
      chk("rst_ready", idx, 32'(req_ready), 32'h0);
      chk("rst_ce",    idx, 32'(mul_ce),    32'h0);
      chk("rst_din0",  idx, mul_din0,       32'h0);
      chk("rst_din1",  idx, mul_din1,       32'h0);
      chk("rst_rv",    idx, 32'(rsp_valid), 32'h0);
      chk("rst_id",    idx, 32'(rsp_id),    32'h0);
      chk("rst_busy",  idx, 32'(busy),      32'h0);
   endtask

   initial begin
      logic [31:0] exp_a, exp_b;

      //              vin      abase         b             rr    ready    ce    rv    id    data          busy
      tv[0]  = '{4'b0001, 32'd7,        32'hFFFFFFFD, 1'b1, 4'b0001, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};
      tv[1]  = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b1, 3'd0, 32'hFFFFFFEB, 1'b1};
      tv[2]  = '{4'b1111, 32'd10,       32'd2,        1'b1, 4'b0010, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};
      tv[3]  = '{4'b1111, 32'd20,       32'd3,        1'b1, 4'b0100, 1'b1, 1'b1, 3'd1, 32'd22,       1'b1};
      tv[4]  = '{4'b1111, 32'd30,       32'd1,        1'b1, 4'b1000, 1'b1, 1'b1, 3'd2, 32'd66,       1'b1};
      tv[5]  = '{4'b1111, 32'd40,       32'd1,        1'b1, 4'b0001, 1'b1, 1'b1, 3'd3, 32'd33,       1'b1};
      tv[6]  = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b1, 3'd0, 32'd40,       1'b1};
      tv[7]  = '{4'b0010, 32'h3FFFFFFF, 32'd4,        1'b1, 4'b0010, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};
      tv[8]  = '{4'b0100, 32'h7FFFFFFE, 32'hFFFFFFFF, 1'b1, 4'b0100, 1'b1, 1'b1, 3'd1, 32'h00000000, 1'b1};
      tv[9]  = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 32'h80000000, 1'b1};
      tv[10] = '{4'b1001, 32'd5,        32'd5,        1'b1, 4'b1000, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};
      tv[11] = '{4'b1001, 32'd5,        32'd5,        1'b1, 4'b0001, 1'b1, 1'b1, 3'd3, 32'd40,       1'b1};
      tv[12] = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b1, 3'd0, 32'd25,       1'b1};
      tv[13] = '{4'b1111, 32'd2,        32'd3,        1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};
      tv[14] = '{4'b1111, 32'd2,        32'd3,        1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 32'd9,        1'b1};
      tv[15] = '{4'b1111, 32'd2,        32'd3,        1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 32'd9,        1'b1};
      tv[16] = '{4'b1111, 32'd2,        32'd3,        1'b0, 4'b0000, 1'b0, 1'b1, 3'd1, 32'd9,        1'b1};
      tv[17] = '{4'b1111, 32'd2,        32'd3,        1'b1, 4'b0100, 1'b1, 1'b1, 3'd1, 32'd9,        1'b1};
      tv[18] = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 32'd12,       1'b1};
      tv[19] = '{4'b0000, 32'd0,        32'd0,        1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 32'h0,        1'b0};

      // Reset state, with every requester asking for a grant.
      reset_n = 1'b0;
      drive(4'b1111, 32'd1, 32'd1, 1'b1);
      #1;
      chk_reset_outputs(0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

`ifndef CONV_FPROP1_MUL_ARB_PRIO_EN
      for (int n = 0; n < 20; n++) begin
         drive(tv[n].vin, tv[n].abase, tv[n].b, tv[n].rr);
         #1;
         exp_a = 32'h0;
         exp_b = 32'h0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (tv[n].exp_ready[i]) begin
               exp_a = tv[n].abase + 32'(i);
               exp_b = tv[n].b;
            end
         end
         chk("ready", n, 32'(req_ready), 32'(tv[n].exp_ready));
         chk("ce",    n, 32'(mul_ce),    32'(tv[n].exp_ce));
         chk("din0",  n, mul_din0,       exp_a);
         chk("din1",  n, mul_din1,       exp_b);
         chk("rv",    n, 32'(rsp_valid), 32'(tv[n].exp_rv));
         chk("busy",  n, 32'(busy),      32'(tv[n].exp_busy));
         if (tv[n].exp_rv) begin
            chk("rid",   n, 32'(rsp_id), 32'(tv[n].exp_id));
            chk("rdata", n, rsp_data,    tv[n].exp_data);
         end
         @(negedge clk);
      end
`else
      // Fixed priority: requester 1 always beats requester 2.
      for (int n = 0; n < 4; n++) begin
         drive(4'b0110, 32'd0, 32'd1, 1'b1);
         #1;
         chk("prio_ready", n, 32'(req_ready), 32'h2);
         @(negedge clk);
      end
      drive(4'b0000, 32'd0, 32'd0, 1'b1);
      repeat (2) @(negedge clk);
`endif

      // Reset while a product is in flight and stalled on the response port.
      drive(4'b0011, 32'd100, 32'd1, 1'b0);
      #1;
      chk("r_grant", 0, 32'(req_ready), 32'h1);
      @(negedge clk);
      #1;
      chk("r_rv", 0, 32'(rsp_valid), 32'h1);
      chk("r_rdata", 0, rsp_data, 32'd100);
      reset_n = 1'b0;
      drive(4'b1111, 32'd100, 32'd1, 1'b1);
      #1;
      chk_reset_outputs(1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      drive(4'b0000, 32'd0, 32'd0, 1'b1);
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("post_rst_rv", n, 32'(rsp_valid), 32'h0);
         chk("post_rst_busy", n, 32'(busy), 32'h0);
         @(negedge clk);
      end
      drive(4'b1111, 32'd6, 32'd7, 1'b1);
      #1;
      chk("post_rst_grant", 0, 32'(req_ready), 32'h1);
      chk("post_rst_ce", 0, 32'(mul_ce), 32'h1);
      @(negedge clk);
      drive(4'b0000, 32'd0, 32'd0, 1'b1);
      #1;
      chk("post_rst_rv", 3, 32'(rsp_valid), 32'h1);
      chk("post_rst_rid", 0, 32'(rsp_id), 32'h0);
      chk("post_rst_rdata", 0, rsp_data, 32'd42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
